param_sync_fifo: RTL
====================

// Module: param_sync_fifo
// PURPOSE
//  Single-clock FIFO, parametrised in width, depth, threshold flags and read mode.
//  Buffers data between producer/consumer logic in one clock domain.
//  Adds fill count, almost-full/almost-empty flags, sticky overflow/underflow
//  error flags and an optional first-word-fall-through (FWFT) read mode.
// PARAMETERS
//  WIDTH      8         data word width in bits (>=1)
//  DEPTH      16        number of entries; power of two, >=2
//  AF_THRESH  DEPTH-2   almost_full asserted when count >= AF_THRESH
//  AE_THRESH  2         almost_empty asserted when count <= AE_THRESH
//  FWFT       0         0 = registered read (1-cycle latency), 1 = first-word-fall-through
// PORTS
//  clk           in   1          single clock, rising edge
//  rst_n         in   1          synchronous, active-low reset
//  wr_en         in   1          write request
//  wr_data       in   WIDTH      write data
//  rd_en         in   1          read request (pop in FWFT mode)
//  rd_data       out  WIDTH      read data
//  rd_valid      out  1          rd_data holds a newly read word
//  full          out  1          count == DEPTH
//  empty         out  1          count == 0
//  almost_full   out  1          count >= AF_THRESH
//  almost_empty  out  1          count <= AE_THRESH
//  count         out  AW+1       current fill level, AW = $clog2(DEPTH)
//  overflow      out  1          sticky: write attempted while full
//  underflow     out  1          sticky: read attempted while empty
//  clr_err       in   1          clears overflow/underflow
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0,
//    almost_empty=1, almost_full=0, overflow=underflow=0, rd_valid=0, rd_data=0.
//    Memory contents are not reset. Mid-operation reset discards all stored words.
//  - Pointers: AW+1-bit binary; index = ptr[AW-1:0]; the MSB is the wrap bit.
//    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]).
//    empty = (wr_ptr == rd_ptr). count = wr_ptr - rd_ptr (mod 2^(AW+1)).
//  - All flags are combinational from the registered pointers/count. They are
//    valid in the cycle after the edge that changed them, with no extra delay.
//  - Write accepted iff wr_en && !full: mem[wr_ptr] <= wr_data, wr_ptr += 1.
//  - Read accepted iff rd_en && !empty: rd_ptr += 1.
//  - Simultaneous accepted write and read: count is unchanged and both pointers advance.
//    When full, a write is rejected even if a read is accepted in the same cycle.
//    When empty, a read is rejected even if a write is accepted in the same cycle.
//  - FWFT=0: rd_data <= mem[rd_ptr] on an accepted read. rd_valid=1 in the next
//    cycle only. Otherwise rd_valid=0 and rd_data holds its previous value.
//  - FWFT=1: rd_data = mem[rd_ptr] combinationally and rd_valid = !empty.
//    An accepted read pops the head word.
//  - Error flags:
//    - overflow  <= 1 on wr_en && full.
//    - underflow <= 1 on rd_en && empty.
//    - clr_err clears both. If a set condition coincides with clr_err, the set wins.
//  - Rejected operations change nothing except the error flags.
// STRUCTURE
//  - Package sync_fifo_pkg: FIFO_DEFAULT_WIDTH/DEPTH constants; typedef struct
//    fifo_status_t {full, empty, almost_full, almost_empty, overflow, underflow}.
//  - Sub-module fifo_mem: WIDTH x DEPTH register array with a synchronous write
//    port and an asynchronous read port.
//  - Pointer, count, flag and read-mode logic live in param_sync_fifo.
// TESTING
//  1. DEPTH=16, FWFT=0: after reset, write 0x00..0x0F on 16 cycles
//     -> almost_full=1 when count=14, full=1 and count=16 after the 16th edge.
//  2. While full, write 0xAA -> overflow=1, count stays 16.
//     Then read 16 times -> rd_data 0x00..0x0F in order, each with a 1-cycle rd_valid.
//  3. At count=5, assert wr_en and rd_en together for 20 cycles
//     -> count stays 5, pointers wrap past 15, output order is preserved.
//  4. When empty, assert rd_en -> underflow=1, rd_valid=0.
//     Pulse clr_err -> underflow=0 next cycle. With clr_err and rd_en together, underflow stays 1.
//  5. FWFT=1: write 0x3C into the empty FIFO -> next cycle rd_valid=1, rd_data=0x3C
//     with no rd_en. Then assert rd_en -> empty=1, rd_valid=0.
//  6. At count=7 with traffic active, assert rst_n=0 for one edge
//     -> count=0, empty=1, all flags at reset values. The next write is read back first.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and the status-flag bundle for the synchronous FIFO.
package sync_fifo_pkg;
  localparam int FIFO_DEFAULT_WIDTH = 8;
  localparam int FIFO_DEFAULT_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;
endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage: synchronous write, asynchronous read, no reset.
// Zero-cycle read latency; no flow control (the caller guards writes).
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with fill count, threshold flags, sticky errors and optional FWFT.
// Read latency 1 cycle (0 in FWFT); writes when full and reads when empty are dropped.
module param_sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_DEFAULT_WIDTH,
  parameter int DEPTH     = FIFO_DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             wr_acc, rd_acc;
  logic             ovf_q, unf_q;
  logic [WIDTH-1:0] mem_rd;
  fifo_status_t     status;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign count               = wr_ptr - rd_ptr;
  assign status.full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign status.empty        = (wr_ptr == rd_ptr);
  assign status.almost_full  = (32'(count) >= AF_THRESH);
  assign status.almost_empty = (32'(count) <= AE_THRESH);
  assign status.overflow     = ovf_q;
  assign status.underflow    = unf_q;

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;

  assign wr_acc = wr_en && !status.full;
  assign rd_acc = rd_en && !status.empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      // A new error in the same cycle as clr_err must not be lost.
      if (wr_en && status.full) ovf_q <= 1'b1;
      else if (clr_err)         ovf_q <= 1'b0;
      if (rd_en && status.empty) unf_q <= 1'b1;
      else if (clr_err)          unf_q <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (mem_rd)
  );

  if (FWFT) begin : g_fwft
    assign rd_data  = mem_rd;
    assign rd_valid = !status.empty;
  end else begin : g_reg
    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= rd_acc;
        if (rd_acc) data_q <= mem_rd;
      end
    end

    assign rd_data  = data_q;
    assign rd_valid = vld_q;
  end
endmodule
